// File: rtl/ps2_host_transmitter_pkg.sv
// Shared definitions for the PS/2 host transmit path: FSM states, command bytes,
// and the frame builder used to serialise one host-to-device byte.
package ps2_host_transmitter_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    INHIBIT      = 3'd1,
    REQUEST      = 3'd2,
    DATA         = 3'd3,
    ACK          = 3'd4,
    WAIT_RELEASE = 3'd5
  } tx_state_e;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] RSP_ACK     = 8'hFA;
  localparam logic [7:0] RSP_BAT_OK  = 8'hAA;

  localparam logic [3:0] FRAME_BITS = 4'd11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Bit 0 is the start bit, bit 10 the stop bit; bit n goes out on falling edge n.
  function automatic logic [10:0] build_frame(input logic [7:0] data);
    return {1'b1, odd_parity(data), data, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one open-drain PS/2 line with a registered
// falling-edge strobe; level and strobe both lag the pin by three cycles.
module ps2_line_sync (
  input  logic clock,
  input  logic reset_n,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;
  logic fall_r;

  // Synchronizer chain; idle lines are high so reset to 1 to avoid a false edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
      fall_r <= 1'b0;
    end else begin
      meta_r <= line;
      sync_r <= meta_r;
      prev_r <= sync_r;
      fall_r <= prev_r & ~sync_r;
    end
  end

  assign level = prev_r;
  assign fall  = fall_r;

endmodule

// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 byte transmitter: inhibit, request-to-send, clock out
// start/data/parity/stop on device falling edges, then check the device ack.
module ps2_host_transmitter
  import ps2_host_transmitter_pkg::*;
#(
  parameter logic [15:0] INHIBIT_CYCLES = 16'd5000,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd750000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       device_clock,
  input  logic       device_data,
  output logic       device_clock_oe,
  output logic       device_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  tx_state_e   state_r, state_s;
  logic [19:0] cnt_r, cnt_s;
  logic [3:0]  idx_r, idx_s;
  logic [10:0] frame_r, frame_s;
  logic        clk_oe_r, clk_oe_s;
  logic        data_oe_r, data_oe_s;
  logic        done_r, done_s;
  logic        error_r, error_s;
  logic        ready_r, ready_s;
  logic        busy_r, busy_s;

  logic        clk_level_s, clk_fall_s;
  logic        data_level_s, data_fall_s;
  logic [19:0] inhibit_last_s;
  logic [19:0] timeout_last_s;
  logic        timeout_s;

  ps2_line_sync u_clock_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (device_clock),
    .level   (clk_level_s),
    .fall    (clk_fall_s)
  );

  ps2_line_sync u_data_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .line    (device_data),
    .level   (data_level_s),
    .fall    (data_fall_s)
  );

  // The REQUEST cycle still holds the clock low, so INHIBIT itself lasts one cycle less.
  assign inhibit_last_s = {4'd0, INHIBIT_CYCLES} - 20'd2;
  assign timeout_last_s = TIMEOUT_CYCLES - 20'd1;
  assign timeout_s      = (cnt_r == timeout_last_s);

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    idx_s     = idx_r;
    frame_s   = frame_r;
    clk_oe_s  = clk_oe_r;
    data_oe_s = data_oe_r;
    done_s    = 1'b0;
    error_s   = 1'b0;
    case (state_r)
      IDLE: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        cnt_s     = 20'd0;
        if (tx_valid && ready_r) begin
          frame_s  = build_frame(tx_data);
          clk_oe_s = 1'b1;
          state_s  = INHIBIT;
        end else begin
          state_s = IDLE;
        end
      end
      INHIBIT: begin
        if (cnt_r == inhibit_last_s) begin
          data_oe_s = ~frame_r[0];
          cnt_s     = 20'd0;
          state_s   = REQUEST;
        end else begin
          cnt_s = cnt_r + 20'd1;
        end
      end
      REQUEST: begin
        clk_oe_s = 1'b0;
        cnt_s    = 20'd0;
        idx_s    = 4'd0;
        state_s  = DATA;
      end
      DATA: begin
        if (clk_fall_s) begin
          cnt_s     = 20'd0;
          idx_s     = idx_r + 4'd1;
          data_oe_s = ~frame_r[idx_r + 4'd1];
          if (idx_r == (FRAME_BITS - 4'd2)) begin
            state_s = ACK;
          end else begin
            state_s = DATA;
          end
        end else if (timeout_s) begin
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b0;
          error_s   = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + 20'd1;
        end
      end
      ACK: begin
        if (clk_fall_s) begin
          cnt_s = 20'd0;
          if (!data_level_s) begin
            state_s = WAIT_RELEASE;
          end else begin
            error_s = 1'b1;
            state_s = IDLE;
          end
        end else if (timeout_s) begin
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b0;
          error_s   = 1'b1;
          state_s   = IDLE;
        end else begin
          cnt_s = cnt_r + 20'd1;
        end
      end
      WAIT_RELEASE: begin
        if (clk_level_s && data_level_s) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else if (timeout_s) begin
          clk_oe_s  = 1'b0;
          data_oe_s = 1'b0;
          error_s   = 1'b1;
          state_s   = IDLE;
        end else if (clk_fall_s) begin
          cnt_s = 20'd0;
        end else begin
          cnt_s = cnt_r + 20'd1;
        end
      end
      default: begin
        clk_oe_s  = 1'b0;
        data_oe_s = 1'b0;
        cnt_s     = 20'd0;
        error_s   = 1'b1;
        state_s   = IDLE;
      end
    endcase
    // Ready is held off during the done/error pulse cycle.
    ready_s = (state_s == IDLE) && !done_s && !error_s;
    busy_s  = (state_s != IDLE);
  end

  // State, counters and registered outputs; reset releases both lines immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= IDLE;
      cnt_r     <= 20'd0;
      idx_r     <= 4'd0;
      frame_r   <= 11'd0;
      clk_oe_r  <= 1'b0;
      data_oe_r <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      idx_r     <= idx_s;
      frame_r   <= frame_s;
      clk_oe_r  <= clk_oe_s;
      data_oe_r <= data_oe_s;
      done_r    <= done_s;
      error_r   <= error_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
    end
  end

  assign device_clock_oe = clk_oe_r;
  assign device_data_oe  = data_oe_r;
  assign tx_ready        = ready_r;
  assign tx_done         = done_r;
  assign tx_error        = error_r;
  assign busy            = busy_r;

  logic unused_s;
  assign unused_s = data_fall_s;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench: a PS/2 device model clocks frames out of the transmitter
// and the captured bits are compared with a frame derived from the byte value.
module tb_ps2_host_transmitter;

  localparam int INHIBIT = 100;
  localparam int TIMEOUT = 1000;
  localparam int HP      = 15;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       device_clock, device_data;
  logic       device_clock_oe, device_data_oe;
  logic       tx_ready, tx_done, tx_error, busy;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, excl_bad = 0, wide_bad = 0;
  logic done_q = 1'b0, err_q = 1'b0;
  int exp_done = 0, exp_err = 0;

  always #5 clock = ~clock;

  // Open-drain wired-AND of host and device pull-downs.
  assign device_clock = ~(device_clock_oe | dev_clk_low);
  assign device_data  = ~(device_data_oe | dev_data_low);

  ps2_host_transmitter #(
    .INHIBIT_CYCLES (16'd100),
    .TIMEOUT_CYCLES (20'd1000)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .device_clock    (device_clock),
    .device_data     (device_data),
    .device_clock_oe (device_clock_oe),
    .device_data_oe  (device_data_oe),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .tx_done         (tx_done),
    .tx_error        (tx_error),
    .busy            (busy)
  );

  // Pulse monitor: counts pulses, flags overlaps and pulses wider than one cycle.
  always @(negedge clock) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_error) err_cnt <= err_cnt + 1;
    if (tx_done && tx_error) excl_bad <= excl_bad + 1;
    if ((tx_done && done_q) || (tx_error && err_q)) wide_bad <= wide_bad + 1;
    done_q <= tx_done;
    err_q  <= tx_error;
  end

  function automatic logic [10:0] ref_frame(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      if (tx_ready === 1'b1) break;
      @(negedge clock);
    end
    chk("ready_before_send", 32'(tx_ready), 32'd1);
  endtask

  // Accept a byte, optionally re-pulse tx_valid while busy, then measure the inhibit.
  task automatic start_send(input logic [7:0] b, input bit pulse_busy);
    int hi;
    logic last_d;
    wait_ready();
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clock);
    tx_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_after_accept", 32'(tx_ready), 32'd0);
    chk("clk_oe_after_accept", 32'(device_clock_oe), 32'd1);
    hi = 0;
    last_d = 1'b0;
    if (pulse_busy) begin
      hi = 1;
      tx_data = ~b;
      tx_valid = 1'b1;
      @(negedge clock);
      tx_valid = 1'b0;
    end
    for (int i = 0; i < 1000; i++) begin
      if (device_clock_oe) begin
        hi++;
        last_d = device_data_oe;
      end else if (hi != 0) begin
        break;
      end
      @(negedge clock);
    end
    chk("inhibit_cycles", 32'(hi), 32'(INHIBIT));
    chk("data_low_before_release", 32'(last_d), 32'd1);
    chk("start_bit_held", 32'(device_data_oe), 32'd1);
  endtask

  // Device side: samples the start bit, then data on each rising clock edge.
  task automatic dev_edges(input int n, input bit ack, output logic [10:0] got);
    got = 11'd0;
    got[0] = device_data;
    repeat (10) @(negedge clock);
    for (int k = 1; k <= n; k++) begin
      if (k == 11 && ack) begin
        dev_data_low = 1'b1;
        repeat (6) @(negedge clock);
      end
      dev_clk_low = 1'b1;
      repeat (HP) @(negedge clock);
      dev_clk_low = 1'b0;
      if (k <= 10) got[k] = device_data;
      repeat (HP) @(negedge clock);
    end
    dev_data_low = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit ack, input bit pulse_busy);
    logic [10:0] got;
    bit seen;
    bit any_busy;
    start_send(b, pulse_busy);
    seen = 1'b0;
    fork
      dev_edges(11, ack, got);
      begin
        for (int i = 0; i < 2000; i++) begin
          @(negedge clock);
          if (tx_done || tx_error) begin
            seen = 1'b1;
            break;
          end
        end
        chk("pulse_seen", 32'(seen), 32'd1);
        chk("done_pulse", 32'(tx_done), 32'(ack));
        chk("error_pulse", 32'(tx_error), 32'(!ack));
        chk("ready_in_pulse", 32'(tx_ready), 32'd0);
        chk("busy_in_pulse", 32'(busy), 32'd0);
        chk("lines_released", 32'({device_clock_oe, device_data_oe}), 32'd0);
        @(negedge clock);
        chk("ready_after_pulse", 32'(tx_ready), 32'd1);
        chk("pulse_one_cycle", 32'({tx_done, tx_error}), 32'd0);
      end
    join
    if (ack) exp_done++;
    else exp_err++;
    chk("frame_bits", 32'(got), 32'(ref_frame(b)));
    if (pulse_busy) begin
      any_busy = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clock);
        if (busy || device_clock_oe) any_busy = 1'b1;
      end
      chk("no_second_frame", 32'(any_busy), 32'd0);
    end
  endtask

  task automatic timeout_test(input logic [7:0] b);
    int n;
    start_send(b, 1'b0);
    n = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (busy && !device_clock_oe) n++;
      else break;
    end
    chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("timeout_error", 32'(tx_error), 32'd1);
    chk("timeout_no_done", 32'(tx_done), 32'd0);
    chk("timeout_lines", 32'({device_clock_oe, device_data_oe}), 32'd0);
    exp_err++;
    @(negedge clock);
    chk("timeout_ready", 32'(tx_ready), 32'd1);
  endtask

  task automatic reset_test();
    logic [10:0] got;
    logic [10:0] exp;
    start_send(8'h00, 1'b0);
    dev_edges(5, 1'b0, got);
    exp = ref_frame(8'h00);
    chk("partial_bits", 32'(got[5:0]), 32'(exp[5:0]));
    chk("data_driven_pre_reset", 32'(device_data_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_async_lines", 32'({device_clock_oe, device_data_oe}), 32'd0);
    chk("reset_async_busy", 32'(busy), 32'd0);
    chk("reset_async_ready", 32'(tx_ready), 32'd1);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    send_frame(8'hF4, 1'b1, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_lines", 32'({device_clock_oe, device_data_oe}), 32'd0);
    chk("reset_ready", 32'(tx_ready), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_pulses", 32'({tx_done, tx_error}), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    send_frame(8'hED, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    for (int r = 0; r < 3; r++) send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0);
    timeout_test(8'($urandom_range(0, 255)));
    reset_test();

    repeat (5) @(negedge clock);
    chk("pulses_exclusive", 32'(excl_bad), 32'd0);
    chk("pulses_single_cycle", 32'(wide_bad), 32'd0);
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    chk("error_total", 32'(err_cnt), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_host_transmitter.md
Name: ps2_host_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends single command bytes to the keyboard, for example 0xFF reset, 0xED set LEDs, the LED argument byte, and 0xF4 enable. It shares the open-drain device_clock/device_data lines with the existing PS/2 receive path. While busy=1, the receive path ignores line activity; the device's 0xFA acknowledge byte is then received there normally.

Parameters:
INHIBIT_CYCLES, 16'd5000, cycles to hold device_clock low before request-to-send (≥100 µs at system clock).
TIMEOUT_CYCLES, 20'd750000, maximum cycles between device_clock falling edges (and from request to first edge) before abort.

Ports:
clock  in  1  system clock; the block's only clock.
reset_n  in  1  asynchronous, active-low reset.
device_clock  in  1  raw PS/2 clock line level (asynchronous).
device_data  in  1  raw PS/2 data line level (asynchronous).
device_clock_oe  out  1  1 = pull PS/2 clock low; 0 = release.
device_data_oe  out  1  1 = pull PS/2 data low; 0 = release.
tx_data  in  8  byte to send.
tx_valid  in  1  send request; accepted when tx_valid & tx_ready.
tx_ready  out  1  1 in IDLE only.
tx_done  out  1  one-cycle pulse: frame acknowledged by device and both lines released.
tx_error  out  1  one-cycle pulse: timeout or missing ack.
busy  out  1  1 from acceptance until return to IDLE.

Behaviour:
- Reset (reset_n=0, asynchronous): both _oe=0 immediately, tx_ready=1, tx_done=0, tx_error=0, busy=0, state=IDLE, counters=0. Reset mid-frame releases both lines at once; no partial frame is resumed.
- Line inputs: each passes through a 2-FF synchronizer. Falling edge = previous synchronized 1, current 0 (one-cycle strobe, 3-cycle latency from the pin).
- Frame: {start=0, d0..d7 LSB first, parity = ~^tx_data (odd), stop=1}, then device ack.
- IDLE: on tx_valid & tx_ready, latch tx_data, compute parity, busy=1, tx_ready=0, go to INHIBIT. tx_valid while not ready is ignored; there is no queue.
- INHIBIT: device_clock_oe=1 for exactly INHIBIT_CYCLES cycles.
- REQUEST (1 cycle): device_data_oe=1 (start bit), then release clock (device_clock_oe=0). Enter DATA with bit index=0 and timeout counter cleared.
- DATA: on falling edges 1..8, drive data bit d(n-1); edge 9 drives parity; edge 10 releases data (stop bit). Drive rule: device_data_oe = ~bit.
- ACK: on falling edge 11, sample synchronized device_data. 0 → WAIT_RELEASE. 1 → tx_error pulse, go to IDLE.
- WAIT_RELEASE: wait until both synchronized lines = 1, then tx_done pulse and IDLE.
- Timeout: counter clears on each falling edge and on state entry into DATA. If it reaches TIMEOUT_CYCLES in DATA, ACK or WAIT_RELEASE: release both lines, tx_error pulse, IDLE.
- tx_done and tx_error are mutually exclusive and each lasts exactly one cycle. tx_ready returns to 1 in the cycle after the pulse.
- A receive-side transfer in progress at acceptance is aborted by the inhibit; this is the intended PS/2 host priority.

Decomposition:
- Shared package: state enum (IDLE, INHIBIT, REQUEST, DATA, ACK, WAIT_RELEASE); PS/2 command constants (CMD_RESET=8'hFF, CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA, RSP_BAT_OK=8'hAA); frame bit count 4'd11.
- Sub-module ps2_line_sync: 2-FF synchronizer plus falling-edge strobe. Instantiate once per line; it is reusable by the receive path.

Test Plan:
- Send 0xED, device model clocks 11 edges and acks → data sampled on rising edges = 0,1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done one pulse; busy low afterwards.
- Send 0x01 → parity bit 0; send 0x00 → parity bit 1; both end in tx_done.
- Inhibit timing: INHIBIT_CYCLES=100 → device_clock_oe high for exactly 100 cycles, then data low before clock release.
- No device clocking (TIMEOUT_CYCLES=1000) → tx_error at 1000 cycles after REQUEST; both _oe=0; tx_ready=1.
- Device leaves data high at edge 11 → tx_error, no tx_done.
- reset_n asserted after edge 5 → _oe drop in the same cycle (async); after release, a new 0xF4 send completes normally. tx_valid pulsed while busy → ignored, no second frame.
